// File: rtl/soft_clock_pkg.sv
// Shared definitions for the soft-clock gate and its controller: command nibbles
// and the controller FSM state encoding.
package soft_clock_pkg;

  localparam logic [3:0] CLOCK_ENABLE  = 4'b1010;
  localparam logic [3:0] CLOCK_DISABLE = 4'b0101;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StBackoff = 2'd2
  } ctrl_state_e;

  function automatic logic [3:0] cmd_nibble(input logic on);
    return on ? CLOCK_ENABLE : CLOCK_DISABLE;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/soft_clock_ctrl_timer.sv
// Loadable down-counter with terminal-count flag; shared by the timeout and backoff
// phases of the soft-clock controller. Saturates at zero.
module soft_clock_ctrl_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/soft_clock_ctrl.sv
// Soft-clock sequencer: turns hold requests into enable/disable writes to the gate with
// timeout, backoff and bounded retry. Optional SOFT_CLOCK_CTRL_STATS_EN adds counters.
module soft_clock_ctrl
  import soft_clock_pkg::*;
#(
  parameter int unsigned C_SIPIF_DWIDTH = 32,
  parameter int unsigned C_NUM_REQ      = 4,
  parameter int unsigned C_TOUT         = 16,
  parameter int unsigned C_BACKOFF      = 8,
  parameter int unsigned C_MAX_RETRY    = 3
) (
  input  logic                        Bus2IP_Clk,
  input  logic                        Bus2IP_Resetn,
  input  logic [C_NUM_REQ-1:0]        Req_Hold,
  output logic [C_NUM_REQ-1:0]        Req_HoldAck,
  output logic                        Ctl2Clk_WrCE,
  output logic [0:C_SIPIF_DWIDTH-1]   Ctl2Clk_Data,
  output logic [0:C_SIPIF_DWIDTH/8-1] Ctl2Clk_BE,
  input  logic                        Clk2Ctl_WrAck,
  input  logic                        Clk2Ctl_Error,
  output logic                        Ctl_ClkOn,
  output logic                        Ctl_Busy,
  output logic                        Ctl_Fault
`ifdef SOFT_CLOCK_CTRL_STATS_EN
  ,
  output logic [15:0]                 Ctl_XferCnt,
  output logic [7:0]                  Ctl_ErrCnt
`endif
);

  localparam int unsigned DW       = C_SIPIF_DWIDTH;
  localparam int unsigned BeW      = C_SIPIF_DWIDTH / 8;
  localparam int unsigned ToutW    = $clog2(C_TOUT);
  localparam int unsigned BackoffW = $clog2(C_BACKOFF + 1);
  localparam int unsigned TimerW   = max_u(ToutW, BackoffW);

  localparam logic [TimerW-1:0] ToutLoad    = TimerW'(C_TOUT - 1);
  localparam logic [TimerW-1:0] BackoffLoad = TimerW'(C_BACKOFF - 1);
  localparam logic [3:0]        MaxRetry    = 4'(C_MAX_RETRY);

  ctrl_state_e          state_q, state_d;
  logic                 target_q, target_d;
  logic                 clk_on_q, clk_on_d;
  logic                 fault_q, fault_d;
  logic [3:0]           retry_q, retry_d, retry_inc;
  logic                 wrce_q, wrce_d;
  logic [0:DW-1]        data_q, data_d;
  logic [0:BeW-1]       be_q, be_d;
  logic [C_NUM_REQ-1:0] hold_ack_q;

  logic                 desired_on;
  logic                 timer_load, timer_en, timer_tc;
  logic [TimerW-1:0]    timer_val;
  logic                 xfer_ok, xfer_fail;

  assign desired_on = ~|Req_Hold;
  assign retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  soft_clock_ctrl_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk     (Bus2IP_Clk),
    .rst_n   (Bus2IP_Resetn),
    .load    (timer_load),
    .load_val(timer_val),
    .en      (timer_en),
    .tc      (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    clk_on_d   = clk_on_q;
    fault_d    = fault_q;
    retry_d    = retry_q;
    timer_load = 1'b0;
    timer_val  = ToutLoad;
    timer_en   = 1'b0;
    xfer_ok    = 1'b0;
    xfer_fail  = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fault_q && (desired_on != clk_on_q)) begin
          target_d   = desired_on;
          timer_load = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        timer_en = 1'b1;
        // WrAck takes priority over Error when both arrive together
        if (Clk2Ctl_WrAck) begin
          xfer_ok  = 1'b1;
          clk_on_d = target_q;
          retry_d  = 4'd0;
          state_d  = StIdle;
        end else if (Clk2Ctl_Error || timer_tc) begin
          xfer_fail = 1'b1;
          retry_d   = retry_inc;
          if (retry_inc >= MaxRetry) begin
            fault_d = 1'b1;
            state_d = StIdle;
          end else begin
            timer_load = 1'b1;
            timer_val  = BackoffLoad;
            state_d    = StBackoff;
          end
        end
      end
      StBackoff: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          timer_load = 1'b1;
          timer_val  = ToutLoad;
          state_d    = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered from the next state so they stay flat across ISSUE
    wrce_d = (state_d == StIssue);
    data_d = '0;
    be_d   = '0;
    if (wrce_d) begin
      data_d[DW-4:DW-1] = cmd_nibble(target_d);
      be_d              = '1;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state_q    <= StIdle;
      target_q   <= 1'b1;
      clk_on_q   <= 1'b1;
      fault_q    <= 1'b0;
      retry_q    <= 4'd0;
      wrce_q     <= 1'b0;
      data_q     <= '0;
      be_q       <= '0;
      hold_ack_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      clk_on_q   <= clk_on_d;
      fault_q    <= fault_d;
      retry_q    <= retry_d;
      wrce_q     <= wrce_d;
      data_q     <= data_d;
      be_q       <= be_d;
      hold_ack_q <= Req_Hold & {C_NUM_REQ{~clk_on_q}};
    end
  end

  assign Req_HoldAck  = hold_ack_q;
  assign Ctl2Clk_WrCE = wrce_q;
  assign Ctl2Clk_Data = data_q;
  assign Ctl2Clk_BE   = be_q;
  assign Ctl_ClkOn    = clk_on_q;
  assign Ctl_Busy     = (state_q != StIdle);
  assign Ctl_Fault    = fault_q;

`ifdef SOFT_CLOCK_CTRL_STATS_EN
  logic [15:0] xfer_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (xfer_ok && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      if (xfer_fail && (err_cnt_q != 8'hFF))   err_cnt_q  <= err_cnt_q + 8'd1;
    end
  end

  assign Ctl_XferCnt = xfer_cnt_q;
  assign Ctl_ErrCnt  = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = xfer_ok ^ xfer_fail;
`endif

endmodule

// File: tb/tb_soft_clock_ctrl.sv
// Scoreboard bench for soft_clock_ctrl: stimulus queues expected write episodes, a
// negedge monitor pops and compares each completed WrCE episode.
module tb_soft_clock_ctrl;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int BW = W / 8;
  localparam logic [3:0] EN_NIB  = 4'b1010;
  localparam logic [3:0] DIS_NIB = 4'b0101;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  hold = '0;
  logic [N-1:0]  hold_ack;
  logic          wrce;
  logic [0:W-1]  data;
  logic [0:BW-1] be;
  logic          wrack, err;
  logic          clk_on, busy, fault;
`ifdef SOFT_CLOCK_CTRL_STATS_EN
  logic [15:0]   xfer_cnt;
  logic [7:0]    err_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  soft_clock_ctrl dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Resetn(rstn),
    .Req_Hold     (hold),
    .Req_HoldAck  (hold_ack),
    .Ctl2Clk_WrCE (wrce),
    .Ctl2Clk_Data (data),
    .Ctl2Clk_BE   (be),
    .Clk2Ctl_WrAck(wrack),
    .Clk2Ctl_Error(err),
    .Ctl_ClkOn    (clk_on),
    .Ctl_Busy     (busy),
    .Ctl_Fault    (fault)
`ifdef SOFT_CLOCK_CTRL_STATS_EN
    ,
    .Ctl_XferCnt  (xfer_cnt),
    .Ctl_ErrCnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Gate model: optional errors, optional ack delay, or total silence
  int wr_cyc     = 0;
  int err_used   = 0;
  int err_budget = 0;
  int ack_delay  = 0;
  bit silent     = 1'b0;

  assign err   = wrce && !silent && (err_used < err_budget);
  assign wrack = wrce && !silent && !(err_used < err_budget) && (wr_cyc >= ack_delay);

  always @(posedge clk) begin
    wr_cyc <= wrce ? wr_cyc + 1 : 0;
    if (err) err_used <= err_used + 1;
  end

  typedef struct {
    logic [3:0] nib;
    int         len;
    int         gap;
  } ep_t;

  ep_t exp_q[$];
  int  ep_pushed = 0;
  int  ep_seen   = 0;
  int  idle_bad  = 0;
  bit  in_ep     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic expect_ep(input logic [3:0] nib, input int len, input int gap);
    ep_t e;
    e.nib = nib;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
    ep_pushed++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      cyc(1);
      if (!busy && !in_ep && exp_q.size() == 0) break;
    end
    if (i == bound) begin
      total_cnt++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, bound);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk_on"}, 32'(clk_on), 32'(1));
    check({tag, "_wrce"}, 32'(wrce), 32'(0));
    check({tag, "_data"}, 32'(data), 32'(0));
    check({tag, "_be"}, 32'(be), 32'(0));
    check({tag, "_hold_ack"}, 32'(hold_ack), 32'(0));
    check({tag, "_fault"}, 32'(fault), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // Monitor: measures each WrCE episode and the idle gap before it
  initial begin
    int           ep_len, gap_len, ep_gap;
    logic [3:0]   ep_nib;
    logic [0:W-1] ep_word, tmp;
    bit           ep_ok;
    ep_t          e;
    gap_len = 0;
    forever begin
      @(negedge clk);
      if (wrce) begin
        if (!in_ep) begin
          in_ep   = 1'b1;
          ep_len  = 1;
          ep_gap  = gap_len;
          ep_word = data;
          ep_nib  = data[W-4:W-1];
          tmp     = data;
          tmp[W-4:W-1] = 4'b0000;
          ep_ok   = (tmp == '0) && (be == '1);
        end else begin
          ep_len++;
          ep_ok = ep_ok && (data == ep_word) && (be == '1);
        end
      end else begin
        if (data != '0 || be != '0) idle_bad++;
        if (in_ep) begin
          in_ep   = 1'b0;
          gap_len = 1;
          ep_seen++;
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got nibble %b len %0d, required no write",
                     ep_nib, ep_len);
          end else begin
            e = exp_q.pop_front();
            check("ep_nibble", 32'(ep_nib), 32'(e.nib));
            check("ep_len", 32'(ep_len), 32'(e.len));
            check("ep_be_data_stable", 32'(ep_ok), 32'(1));
            if (e.gap >= 0) check("ep_gap", 32'(ep_gap), 32'(e.gap));
          end
        end else begin
          gap_len++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
    rstn = 1'b0;
    cyc(3);
    rstn = 1'b1;
    check_reset_vals("reset");

    // 1: single disable with immediate ack
    hold = 4'b0010;
    expect_ep(DIS_NIB, 1, -1);
    cyc(1);
    check("t1_wrce_latency", 32'(wrce), 32'(1));
    check("t1_clk_on_still_1", 32'(clk_on), 32'(1));
    cyc(1);
    check("t1_clk_on_0", 32'(clk_on), 32'(0));
    check("t1_hold_ack_early", 32'(hold_ack), 32'(0));
    cyc(1);
    check("t1_hold_ack", 32'(hold_ack), 32'(4'b0010));

    // 2: release, then overlapping holds produce one disable only
    hold = 4'b0000;
    expect_ep(EN_NIB, 1, -1);
    cyc(1);
    check("t2_hold_ack_drop", 32'(hold_ack), 32'(0));
    cyc(1);
    check("t2_clk_on_1", 32'(clk_on), 32'(1));
    hold = 4'b0011;
    expect_ep(DIS_NIB, 1, -1);
    wait_idle("t2_wait_dis", 50);
    hold = 4'b0001;
    cyc(4);
    check("t2_hold_ack_0001", 32'(hold_ack), 32'(4'b0001));
    check("t2_clk_on_held", 32'(clk_on), 32'(0));
    hold = 4'b0000;
    expect_ep(EN_NIB, 1, -1);
    wait_idle("t2_wait_en", 50);
    check("t2_clk_on_final", 32'(clk_on), 32'(1));

    // 3: two errors then ack
    err_budget = err_used + 2;
    hold = 4'b0001;
    expect_ep(DIS_NIB, 1, -1);
    expect_ep(DIS_NIB, 1, 8);
    expect_ep(DIS_NIB, 1, 8);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (busy) n++;
      else if (n > 0) break;
    end
    check("t3_busy_cycles", 32'(n), 32'(19));
    check("t3_clk_on_0", 32'(clk_on), 32'(0));
    check("t3_fault_0", 32'(fault), 32'(0));
    wait_idle("t3_drain", 20);
    hold = 4'b0000;
    expect_ep(EN_NIB, 1, -1);
    wait_idle("t3_wait_en", 50);
    check("t3_clk_on_1", 32'(clk_on), 32'(1));

    // 5: hold pulse during delayed-ack ISSUE; reversal follows immediately
    ack_delay = 5;
    hold = 4'b0001;
    expect_ep(DIS_NIB, 6, -1);
    expect_ep(EN_NIB, 6, 1);
    cyc(1);
    hold = 4'b0000;
    wait_idle("t5_wait", 100);
    check("t5_clk_on_1", 32'(clk_on), 32'(1));
    check("t5_hold_ack", 32'(hold_ack), 32'(0));
    ack_delay = 0;

    // 6: reset mid-BACKOFF
    err_budget = err_used + 1000;
    hold = 4'b0001;
    expect_ep(DIS_NIB, 1, -1);
    cyc(4);
    check("t6_in_backoff_busy", 32'(busy), 32'(1));
    check("t6_in_backoff_wrce", 32'(wrce), 32'(0));
    rstn = 1'b0;
    hold = 4'b0000;
    cyc(1);
    check_reset_vals("t6_reset");
`ifdef SOFT_CLOCK_CTRL_STATS_EN
    check("t6_xfer_cnt", 32'(xfer_cnt), 32'(0));
    check("t6_err_cnt", 32'(err_cnt), 32'(0));
`endif
    rstn = 1'b1;
    err_budget = err_used;
    cyc(2);

    // 4: silent gate exhausts retries and faults
    silent = 1'b1;
    hold = 4'b0001;
    expect_ep(DIS_NIB, 16, -1);
    expect_ep(DIS_NIB, 16, 8);
    expect_ep(DIS_NIB, 16, 8);
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (fault) begin
        done = 1'b1;
        break;
      end
    end
    check("t4_fault_set", 32'(done), 32'(1));
    wait_idle("t4_drain", 20);
    check("t4_clk_on_1", 32'(clk_on), 32'(1));
    check("t4_busy_0", 32'(busy), 32'(0));
    hold = 4'b0000;
    cyc(5);
    hold = 4'b0010;
    cyc(5);
    hold = 4'b0000;
    cyc(40);
    check("t4_fault_sticky", 32'(fault), 32'(1));
    check("episode_count", 32'(ep_seen), 32'(ep_pushed));
    check("pending_expected", 32'(exp_q.size()), 32'(0));
    check("idle_bus_zero", 32'(idle_bad), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
